// File: rtl/sar_adc_pkg.sv
// sar_adc_pkg: shared states and defaults for the SAR ADC conversion controller.
package sar_adc_pkg;
    typedef enum logic [1:0] {IDLE, SAMPLE, CONVERT, DONE} state_t;
    localparam int DEF_WIDTH = 10;
    localparam int DEF_SAMPLE_CYCLES = 4;
    // Comparator level meaning "held voltage >= DAC voltage", i.e. keep the trial bit
    localparam logic CMP_ABOVE = 1'b1;
endpackage

// File: rtl/sar_tick_gen.sv
// sar_tick_gen: rising-edge detector for the slow sys_clk, sampled in the clk domain.
module sar_tick_gen (
    input  logic clk,
    input  logic reset,
    input  logic sys_clk,
    output logic tick
);
    logic sys_clk_q;
    always_ff @(posedge clk) sys_clk_q <= reset ? 1'b0 : sys_clk;
    assign tick = sys_clk & ~sys_clk_q;
endmodule

// File: rtl/sar_conversion_controller.sv
// sar_conversion_controller: SAR sequencer (track/hold, bitwise trial search, start/done handshake).
// Defining SAR_CTRL_SYSCLK_GATE_EN makes SAMPLE and CONVERT advance only on sys_clk rising edges.
module sar_conversion_controller
    import sar_adc_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SAMPLE_CYCLES = DEF_SAMPLE_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sys_clk,
    input  logic             start,
    input  logic             cmp_in,
    output logic             hold_ctrl,
    output logic [WIDTH-1:0] dac_code,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);
    localparam int CW = $clog2(SAMPLE_CYCLES + 1);
    localparam int IW = $clog2(WIDTH + 1);

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [IW-1:0]    idx, idx_n;
    logic [WIDTH-1:0] trial, trial_n, result_n, mask;
    logic             tick;

`ifdef SAR_CTRL_SYSCLK_GATE_EN
    sar_tick_gen u_tick (.clk(clk), .reset(reset), .sys_clk(sys_clk), .tick(tick));
`else
    logic unused_sys_clk;
    assign unused_sys_clk = sys_clk;
    assign tick = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            idx    <= '0;
            trial  <= '0;
            result <= '0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            idx    <= idx_n;
            trial  <= trial_n;
            result <= result_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        idx_n    = idx;
        trial_n  = trial;
        result_n = result;
        mask     = WIDTH'(1) << idx;
        case (state)
            IDLE: if (start) begin
                state_n = SAMPLE;
                cnt_n   = CW'(SAMPLE_CYCLES - 1);
            end
            SAMPLE: if (tick) begin
                if (cnt == '0) begin
                    state_n = CONVERT;
                    trial_n = WIDTH'(1) << (WIDTH - 1);
                    idx_n   = IW'(WIDTH - 1);
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            CONVERT: if (tick) begin
                // Resolve the current bit and raise the next lower trial bit in one step
                trial_n = (trial & ~mask) | ((cmp_in == CMP_ABOVE) ? mask : '0)
                        | ((idx != '0) ? (mask >> 1) : '0);
                if (idx == '0) begin
                    state_n  = DONE;
                    result_n = trial_n;
                end else begin
                    idx_n = idx - IW'(1);
                end
            end
            DONE: begin
                state_n = start ? SAMPLE : IDLE;
                cnt_n   = CW'(SAMPLE_CYCLES - 1);
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy      = (state == SAMPLE) || (state == CONVERT);
    assign done      = (state == DONE);
    assign hold_ctrl = (state == CONVERT) || (state == DONE);
    assign dac_code  = (state == CONVERT) ? trial : (state == DONE) ? result : '0;
endmodule

// File: tb/tb_sar_conversion_controller.sv
// tb_sar_conversion_controller: randomized bench with a binary-search reference model.
module tb_sar_conversion_controller;
    logic       clk = 0, reset = 1, sys_clk = 0, start = 0;
    logic       hold_ctrl, busy, done, cmp_in;
    logic [9:0] dac_code, result;
    int         held = 0;
    int         checks = 0, errors = 0;

    always #5 clk = ~clk;
`ifdef SAR_CTRL_SYSCLK_GATE_EN
    always #20 sys_clk = ~sys_clk;
`endif

    assign cmp_in = (held >= int'(dac_code));

    sar_conversion_controller dut (
        .clk(clk), .reset(reset), .sys_clk(sys_clk), .start(start), .cmp_in(cmp_in),
        .hold_ctrl(hold_ctrl), .dac_code(dac_code), .busy(busy), .done(done), .result(result)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    // Successive approximation as a plain binary search over the 10-bit range
    function automatic int model_result(input int h);
        int code = 0;
        for (int b = 9; b >= 0; b--) if (h >= (code | (1 << b))) code |= 1 << b;
        return code;
    endfunction

    task automatic run_conv(input int h);
        int exp_seq[$];
        int seen[$];
        int code = 0;
        int n = 0;
        held = h;
        for (int b = 9; b >= 0; b--) begin
            exp_seq.push_back(code | (1 << b));
            if (h >= (code | (1 << b))) code |= 1 << b;
        end
        @(negedge clk);
        start = 1;
        @(posedge clk);
        #1 start = 0;
        while (!done && n < 400) begin
            @(posedge clk);
            n++;
            #1;
            if (hold_ctrl && busy && (seen.size() == 0 || seen[$] != int'(dac_code)))
                seen.push_back(int'(dac_code));
        end
        check("done_seen", int'(done), 1);
`ifndef SAR_CTRL_SYSCLK_GATE_EN
        check("latency", n, 14);
`endif
        check("n_steps", seen.size(), 10);
        for (int i = 0; i < 10; i++) check("dac_step", (i < seen.size()) ? seen[i] : -1, exp_seq[i]);
        check("result", int'(result), code);
        check("done_dac", int'(dac_code), code);
        check("done_busy", int'(busy), 0);
        check("done_hold", int'(hold_ctrl), 1);
        @(posedge clk);
        #1;
        check("done_single", int'(done), 0);
    endtask

    initial begin
        int h, dcount, consec, prev;
        repeat (3) @(posedge clk);
        #1;
        check("rst_hold", int'(hold_ctrl), 0);
        check("rst_dac", int'(dac_code), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_result", int'(result), 0);
        reset = 0;
        run_conv(677);
        run_conv(0);
        run_conv(1023);
        run_conv(300);
        repeat (8) run_conv($urandom_range(0, 1023));

`ifndef SAR_CTRL_SYSCLK_GATE_EN
        // start held high: back-to-back conversions every 15 cycles
        h = $urandom_range(0, 1023);
        held = h;
        dcount = 0; consec = 0; prev = 0;
        @(negedge clk);
        start = 1;
        @(posedge clk);
        for (int n = 1; n <= 44; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                dcount++;
                check("b2b_result", int'(result), model_result(h));
            end
            if (done && prev) consec++;
            prev = int'(done);
        end
        start = 0;
        check("b2b_count", dcount, 3);
        check("b2b_consec", consec, 0);
        @(posedge clk);
        #1;
        check("b2b_idle", int'(busy) + int'(done), 0);
`endif

        // start pulses while busy must not add conversions
        h = $urandom_range(0, 1023);
        held = h;
        dcount = 0;
        @(negedge clk);
        start = 1;
        @(posedge clk);
        #1;
        for (int i = 1; i <= 150; i++) begin
            start = (i < 10) ? 1'($urandom_range(0, 1)) : 1'b0;
            @(posedge clk);
            #1;
            if (done) begin
                dcount++;
                check("pulse_result", int'(result), model_result(h));
            end
        end
        check("pulse_count", dcount, 1);

        // reset on the 5th CONVERT step
        run_conv($urandom_range(512, 1023));
        held = $urandom_range(0, 1023);
        @(negedge clk);
        start = 1;
        @(posedge clk);
        #1 start = 0;
        repeat (8) @(posedge clk);
        #1 reset = 1;
        @(posedge clk);
        #1;
        check("mid_rst_hold", int'(hold_ctrl), 0);
        check("mid_rst_dac", int'(dac_code), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_done", int'(done), 0);
        check("mid_rst_result", int'(result), 0);
        reset = 0;
        @(posedge clk);
        #1;
        check("mid_rst_idle", int'(busy), 0);
        run_conv($urandom_range(0, 1023));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
